timer_counter_8bit: RTL and testbench
=====================================

# timer_counter_8bit

8-bit up/down timer/counter with an APB slave register interface, used with a companion `prescaler` sub-block that divides `pclk` into four count-tick sources. Software loads a start value, picks the count direction and tick rate, and enables counting. The block raises sticky overflow and underflow flags that drive interrupt-style outputs. Everything runs in the single `pclk` domain.

## Interface
Parameters:
- DATA_WIDTH, 8: APB data width and counter width.
- ADDR_WIDTH, 3: APB address width.

Ports (timer_counter_8bit):
- pclk  input  1: the only clock; all logic on its rising edge.
- preset_n  input  1: reset; synchronous, active-high.
- clk_in  input  4: tick sources from `prescaler`, sampled as data in the `pclk` domain.
- psel, penable, pwrite  input  1 each: APB control.
- paddr  input  ADDR_WIDTH: register address.
- pwdata  input  DATA_WIDTH: write data.
- prdata  output  DATA_WIDTH: read data.
- pready  output  1: transfer-complete indication.
- pslverr  output  1: transfer error.
- TMR_OVF  output  1: overflow flag, equal to TSR[0].
- TMR_UDF  output  1: underflow flag, equal to TSR[1].

Ports (prescaler):
- clk_in  input  1: connected to `pclk`.
- reset_n  input  1: synchronous, active-high reset.
- clk_0, clk_1, clk_2, clk_3  output  1 each: pclk/2, /4, /8, /16.

## Operation
Prescaler:
- Free-running 4-bit counter `div`, incremented every `pclk`.
- `clk_k = div[k]`.
- On reset, `div = 0` and all outputs are 0.

Register map:
- 3'b001 TSR (status): [0] OVF, [1] UDF, [7:2] read 0.
- 3'b010 TDR (load value): read/write.
- 3'b011 TCR (control): read/write. Fields:
  - [7] load.
  - [5] direction: 1 = down, 0 = up.
  - [4] enable.
  - [1:0] cks: selects clk_in[cks]; 00 = pclk/2, 01 = /4, 10 = /8, 11 = /16.
  - [6], [3:2] are reserved: they read 0 and writes to them are ignored.
- 3'b100 TCNT: read-only counter value.
- Any other address is invalid.

APB:
- Zero wait states: `pready = psel & penable`.
- Write: takes effect at the `pclk` edge where `psel & penable & pwrite` and the address is writable. Repeated back-to-back access phases each perform a write.
- Read: `prdata` is combinational. It shows the addressed register when `psel & !pwrite`, otherwise 0.
- `pslverr = psel & penable & (invalid address | write to TCNT)`. An erroring write changes no state.
- TSR writes: writing 0 to a bit clears it; writing 1 has no effect.

Counting:
- Tick detection: a 4-bit register `prev` samples all of `clk_in` every cycle. `tick = clk_in[cks] & ~prev[cks]`.
  - Because all four bits are tracked, changing cks produces no spurious tick unless the new source truly rose.
- Priority at each `pclk` edge:
  1. If TCR[7] = 1: TCNT <= TDR. No counting and no flag update.
  2. Else if TCR[4] = 1 and tick: TCNT <= TCNT ± 1, wrapping mod 256.
  3. Else: TCNT holds.
- Up count from 8'hFF to 8'h00 sets TSR[0].
- Down count from 8'h00 to 8'hFF sets TSR[1].
- Flags are sticky until cleared by software.
- If a flag-set and a software clear of the same bit occur in the same cycle, the set wins.
- Clearing enable freezes TCNT. Re-enabling resumes from the held value.
- A TDR write while counting does not affect TCNT until the next load.

## Timing
- Reset values: TDR, TCR, TSR, TCNT, `prev` all 0; prdata = 0; TMR_OVF = 0; TMR_UDF = 0.
- Reset applied mid-count clears everything at the next `pclk` edge.
- Register writes are visible on readback in the cycle after the write edge.
- Load latency: TCNT equals TDR one `pclk` after the edge at which TCR[7] = 1 is sampled.
- Count latency: `tick` is combinational from `clk_in` and `prev`. TCNT updates at the same edge where `tick` is high, so one cycle after the prescaler bit rises.
- Count rate: the count period is 2^(cks+1) `pclk` cycles.
- Flag latency: the flag sets at the same edge as the wrapping TCNT update, so TMR_OVF/TMR_UDF go high in the same cycle TCNT shows the wrapped value.

## Test plan
- Reset: hold preset_n = 1 for 2 cycles → all reads return 0, pready = 0, TMR_OVF = TMR_UDF = 0, prescaler outputs 0.
- Down count with underflow:
  - Write TDR = 8'h05, then TCR = 8'hA0, then TCR = 8'h30 (pclk/2).
  - → TCNT = 5, 4, 3, 2, 1, 0, FF, one step every 2 pclk cycles.
  - → TMR_UDF rises exactly with the 0 → FF step; TMR_OVF stays 0.
- Up count with overflow:
  - Write TDR = 8'hFD, then TCR = 8'h80, then TCR = 8'h13 (up, pclk/16).
  - → FE, FF, 00 at 16-cycle spacing; TMR_OVF = 1 at the FF → 00 step.
  - Then write TSR = 8'h00 → TMR_OVF = 0.
- Freeze:
  - Write TCR = 8'h20 mid-count → TCNT holds for 100 cycles.
  - Write TCR = 8'h30 → counting resumes from the held value.
- APB errors:
  - Write to addr 3'b100 or 3'b111 → pslverr = 1 during the access phase, and no register changes.
  - Read of addr 3'b111 → prdata = 0, pslverr = 1.
- Load priority: TCR = 8'hB0 (load + enable) with TDR = 8'h42 → TCNT stays 8'h42 with no flags set.

Source files
------------

// File: rtl/timer_counter_8bit.sv
// 8-bit up/down timer/counter with an APB register file, plus the free-running
// prescaler that supplies its four tick sources. Single pclk domain throughout.

module prescaler (
  input  logic clk_in,
  input  logic reset_n,
  output logic clk_0,
  output logic clk_1,
  output logic clk_2,
  output logic clk_3
);

  logic [3:0] div_q;
  logic [3:0] div_d;

  // Free-running divider; each bit toggles at half the rate of the one below.
  always_comb begin
    div_d = div_q + 4'd1;
  end

  // Divider state, cleared by the (active-high) synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_n) begin
      div_q <= 4'd0;
    end else begin
      div_q <= div_d;
    end
  end

  assign clk_0 = div_q[0];
  assign clk_1 = div_q[1];
  assign clk_2 = div_q[2];
  assign clk_3 = div_q[3];

endmodule

module timer_counter_8bit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic [3:0]            clk_in,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  TMR_OVF,
  output logic                  TMR_UDF
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TSR  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TDR  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TCR  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TCNT = ADDR_WIDTH'(4);

  // Only load, direction, enable and cks are implemented in TCR.
  localparam logic [DATA_WIDTH-1:0] TCR_MASK = DATA_WIDTH'(8'hB3);

  localparam int TCR_LOAD = 7;
  localparam int TCR_DIR  = 5;
  localparam int TCR_EN   = 4;

  logic [1:0]            tsr_q, tsr_d;
  logic [DATA_WIDTH-1:0] tdr_q, tdr_d;
  logic [DATA_WIDTH-1:0] tcr_q, tcr_d;
  logic [DATA_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [3:0]            prev_q;

  logic                  access_s;
  logic                  addr_valid_s;
  logic                  err_s;
  logic                  wr_ok_s;
  logic                  wr_tsr_s;
  logic                  wr_tdr_s;
  logic                  wr_tcr_s;
  logic [1:0]            cks_s;
  logic                  tick_s;
  logic                  ovf_set_s;
  logic                  udf_set_s;
  logic [DATA_WIDTH-1:0] rd_s;

  // APB access qualification and address decode.
  always_comb begin
    access_s = psel & penable;
    case (paddr)
      ADDR_TSR, ADDR_TDR, ADDR_TCR, ADDR_TCNT: addr_valid_s = 1'b1;
      default:                                addr_valid_s = 1'b0;
    endcase
    err_s    = access_s & (~addr_valid_s | (pwrite & (paddr == ADDR_TCNT)));
    wr_ok_s  = access_s & pwrite & ~err_s;
    wr_tsr_s = wr_ok_s & (paddr == ADDR_TSR);
    wr_tdr_s = wr_ok_s & (paddr == ADDR_TDR);
    wr_tcr_s = wr_ok_s & (paddr == ADDR_TCR);
  end

  // Edge detect on the selected source; prev tracks all four so switching
  // cks never fabricates a rising edge.
  always_comb begin
    cks_s  = tcr_q[1:0];
    tick_s = clk_in[cks_s] & ~prev_q[cks_s];
  end

  // Counter next state: load beats counting, and a load never touches flags.
  always_comb begin
    tcnt_d    = tcnt_q;
    ovf_set_s = 1'b0;
    udf_set_s = 1'b0;
    if (tcr_q[TCR_LOAD]) begin
      tcnt_d = tdr_q;
    end else if (tcr_q[TCR_EN] && tick_s) begin
      if (tcr_q[TCR_DIR]) begin
        tcnt_d    = tcnt_q - DATA_WIDTH'(1);
        udf_set_s = (tcnt_q == '0);
      end else begin
        tcnt_d    = tcnt_q + DATA_WIDTH'(1);
        ovf_set_s = (tcnt_q == '1);
      end
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  // Register write path; a hardware flag set overrides a same-cycle clear.
  always_comb begin
    tsr_d = tsr_q;
    if (wr_tsr_s) begin
      tsr_d = tsr_q & pwdata[1:0];
    end else begin
      tsr_d = tsr_q;
    end
    if (ovf_set_s) begin
      tsr_d[0] = 1'b1;
    end else begin
      tsr_d[0] = tsr_d[0];
    end
    if (udf_set_s) begin
      tsr_d[1] = 1'b1;
    end else begin
      tsr_d[1] = tsr_d[1];
    end
    tdr_d = wr_tdr_s ? pwdata : tdr_q;
    tcr_d = wr_tcr_s ? (pwdata & TCR_MASK) : tcr_q;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge pclk) begin
    if (preset_n) begin
      tsr_q  <= 2'b00;
      tdr_q  <= '0;
      tcr_q  <= '0;
      tcnt_q <= '0;
      prev_q <= 4'b0000;
    end else begin
      tsr_q  <= tsr_d;
      tdr_q  <= tdr_d;
      tcr_q  <= tcr_d;
      tcnt_q <= tcnt_d;
      prev_q <= clk_in;
    end
  end

  // Combinational read mux, active whenever a read is being addressed.
  always_comb begin
    rd_s = '0;
    if (psel && !pwrite) begin
      case (paddr)
        ADDR_TSR:  rd_s = {{(DATA_WIDTH-2){1'b0}}, tsr_q};
        ADDR_TDR:  rd_s = tdr_q;
        ADDR_TCR:  rd_s = tcr_q;
        ADDR_TCNT: rd_s = tcnt_q;
        default:   rd_s = '0;
      endcase
    end else begin
      rd_s = '0;
    end
  end

  assign prdata  = rd_s;
  assign pready  = access_s;
  assign pslverr = err_s;
  assign TMR_OVF = tsr_q[0];
  assign TMR_UDF = tsr_q[1];

endmodule

// File: tb/tb_timer_counter_8bit.sv
// Self-checking bench: directed scenarios plus randomized APB/tick traffic,
// all checked every cycle against a behavioural model of the register map.

module tb_timer_counter_8bit;

  logic       pclk = 1'b0;
  logic       preset_n = 1'b1;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0] paddr = 3'd0;
  logic [7:0] pwdata = 8'd0;
  logic [7:0] prdata;
  logic       pready, pslverr, TMR_OVF, TMR_UDF;
  logic       c0, c1, c2, c3;
  logic [3:0] clk_in;
  logic [3:0] rand_clk = 4'd0;
  logic       use_rand = 1'b0;
  logic       started = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  int m_tdr = 0, m_tcr = 0, m_tsr = 0, m_tcnt = 0, m_prev = 0, m_div = 0;

  always #5 pclk = ~pclk;

  prescaler u_pre (
    .clk_in (pclk),
    .reset_n(preset_n),
    .clk_0  (c0),
    .clk_1  (c1),
    .clk_2  (c2),
    .clk_3  (c3)
  );

  assign clk_in = use_rand ? rand_clk : {c3, c2, c1, c0};

  timer_counter_8bit #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .clk_in  (clk_in),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .TMR_OVF (TMR_OVF),
    .TMR_UDF (TMR_UDF)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register map semantics applied once per pclk edge.
  always @(posedge pclk) begin : model_upd
    int clkin, cks, tick, acc, err, wr, nt, ntsr, a;
    clkin = use_rand ? int'(rand_clk) : m_div;
    a = int'(paddr);
    if (preset_n) begin
      m_tdr = 0; m_tcr = 0; m_tsr = 0; m_tcnt = 0; m_prev = 0; m_div = 0;
    end else begin
      acc  = (psel && penable) ? 1 : 0;
      err  = (acc != 0 && (a < 1 || a > 4 || (pwrite && a == 4))) ? 1 : 0;
      wr   = (acc != 0 && pwrite && err == 0) ? 1 : 0;
      cks  = m_tcr % 4;
      tick = ((((clkin >> cks) & 1) == 1) && (((m_prev >> cks) & 1) == 0)) ? 1 : 0;
      nt   = m_tcnt;
      ntsr = m_tsr;
      if (wr != 0 && a == 1) begin
        if (!pwdata[0]) ntsr = ntsr & 2;
        if (!pwdata[1]) ntsr = ntsr & 1;
      end
      if (m_tcr >= 128) begin
        nt = m_tdr;
      end else if ((m_tcr & 16) != 0 && tick != 0) begin
        if ((m_tcr & 32) != 0) begin
          if (m_tcnt == 0) begin nt = 255; ntsr = ntsr | 2; end
          else nt = m_tcnt - 1;
        end else begin
          if (m_tcnt == 255) begin nt = 0; ntsr = ntsr | 1; end
          else nt = m_tcnt + 1;
        end
      end
      if (wr != 0 && a == 2) m_tdr = int'(pwdata);
      if (wr != 0 && a == 3) m_tcr = int'(pwdata) & 'hB3;
      m_tcnt = nt;
      m_tsr  = ntsr;
      m_prev = clkin;
      m_div  = (m_div + 1) % 16;
    end
  end

  function automatic logic [7:0] exp_rd();
    logic [7:0] r;
    r = 8'd0;
    if (psel && !pwrite) begin
      case (paddr)
        3'd1:    r = 8'(m_tsr);
        3'd2:    r = 8'(m_tdr);
        3'd3:    r = 8'(m_tcr);
        3'd4:    r = 8'(m_tcnt);
        default: r = 8'd0;
      endcase
    end
    return r;
  endfunction

  function automatic logic exp_err();
    return psel && penable && (paddr < 3'd1 || paddr > 3'd4 || (pwrite && paddr == 3'd4));
  endfunction

  // Per-cycle compare of every observable output against the model.
  always @(negedge pclk) begin
    #1;
    if (started) begin
      check("prdata",  32'(prdata),  32'(exp_rd()));
      check("pready",  32'(pready),  32'(psel && penable));
      check("pslverr", 32'(pslverr), 32'(exp_err()));
      check("TMR_OVF", 32'(TMR_OVF), 32'(m_tsr & 1));
      check("TMR_UDF", 32'(TMR_UDF), 32'((m_tsr >> 1) & 1));
      check("prescaler", 32'({c3, c2, c1, c0}), 32'(m_div));
    end
  end

  always @(negedge pclk) begin
    if (use_rand) rand_clk = 4'($urandom);
  end

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d, input int reps,
                           output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    for (int i = 0; i < reps; i++) begin
      @(negedge pclk);
      penable = 1'b1;
      #1 err = pslverr;
    end
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd4;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] rd, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1 rd = prdata; err = pslverr;
    @(negedge pclk);
    penable = 1'b0; paddr = 3'd4;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic e;
    apb_write(a, d, 1, e);
  endtask

  // Waits for TCNT (idle-monitored) to differ from cur; returns cycles waited.
  task automatic wait_change(input logic [7:0] cur, input int limit, output int cyc);
    cyc = 0;
    while (prdata === cur && cyc < limit) begin
      @(negedge pclk); #1;
      cyc++;
    end
  endtask

  initial begin
    logic       e;
    logic [7:0] rd;
    logic [7:0] seq[$];
    int         gaps[$];
    int         cyc, v;
    logic       udf_at_ff, udf_at_0, ovf_at_00, ovf_at_ff;

    // Reset and its observable state.
    preset_n = 1'b1;
    repeat (2) @(posedge pclk);
    started = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge pclk);
      psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 3'(k);
      #1 check("reset_read", 32'(prdata), 32'h0);
    end
    check("reset_pready", 32'(pready), 32'h0);
    check("reset_flags", 32'({TMR_UDF, TMR_OVF}), 32'h0);
    check("reset_prescaler", 32'({c3, c2, c1, c0}), 32'h0);
    @(negedge pclk);
    preset_n = 1'b0;

    // Down count through underflow at pclk/2.
    apb_write(3'd2, 8'h05, 1, e);
    check("valid_write_err", 32'(e), 32'h0);
    wr(3'd3, 8'hA0);
    wr(3'd3, 8'h30);
    #1 seq.push_back(prdata);
    udf_at_0 = 1'b1; udf_at_ff = 1'b0;
    while (seq.size() < 7) begin
      wait_change(seq[$], 20, cyc);
      if (cyc >= 20) break;
      seq.push_back(prdata);
      gaps.push_back(cyc);
      if (prdata == 8'h00) udf_at_0 = TMR_UDF;
      if (prdata == 8'hFF) udf_at_ff = TMR_UDF;
    end
    check("down_steps", 32'(seq.size()), 32'd7);
    for (int i = 0; i < seq.size(); i++)
      check("down_value", 32'(seq[i]), 32'((5 - i) & 8'hFF));
    for (int i = 1; i < gaps.size(); i++)
      check("down_spacing", 32'(gaps[i]), 32'd2);
    check("udf_before_wrap", 32'(udf_at_0), 32'h0);
    check("udf_at_wrap", 32'(udf_at_ff), 32'h1);
    check("ovf_after_down", 32'(TMR_OVF), 32'h0);

    // Up count through overflow at pclk/16.
    seq.delete(); gaps.delete();
    wr(3'd2, 8'hFD);
    wr(3'd3, 8'h80);
    wr(3'd3, 8'h13);
    #1 seq.push_back(prdata);
    ovf_at_ff = 1'b1; ovf_at_00 = 1'b0;
    while (seq.size() < 4) begin
      wait_change(seq[$], 40, cyc);
      if (cyc >= 40) break;
      seq.push_back(prdata);
      gaps.push_back(cyc);
      if (prdata == 8'hFF) ovf_at_ff = TMR_OVF;
      if (prdata == 8'h00) ovf_at_00 = TMR_OVF;
    end
    check("up_steps", 32'(seq.size()), 32'd4);
    for (int i = 0; i < seq.size(); i++)
      check("up_value", 32'(seq[i]), 32'((8'hFD + i) & 8'hFF));
    for (int i = 1; i < gaps.size(); i++)
      check("up_spacing", 32'(gaps[i]), 32'd16);
    check("ovf_before_wrap", 32'(ovf_at_ff), 32'h0);
    check("ovf_at_wrap", 32'(ovf_at_00), 32'h1);
    wr(3'd1, 8'h00);
    #1 check("ovf_cleared", 32'({TMR_UDF, TMR_OVF}), 32'h0);

    // Freeze and resume.
    wr(3'd3, 8'h20);
    v = m_tcnt;
    repeat (100) @(negedge pclk);
    #1 check("freeze_hold", 32'(prdata), 32'(v));
    wr(3'd3, 8'h30);
    #1 wait_change(8'(v), 10, cyc);
    check("resume_value", 32'(prdata), 32'((v - 1) & 8'hFF));

    // APB errors.
    apb_write(3'd4, 8'h55, 1, e);
    check("err_write_tcnt", 32'(e), 32'h1);
    apb_write(3'd7, 8'h55, 1, e);
    check("err_write_invalid", 32'(e), 32'h1);
    apb_read(3'd7, rd, e);
    check("err_read_data", 32'(rd), 32'h0);
    check("err_read_flag", 32'(e), 32'h1);

    // Load has priority over enable.
    wr(3'd2, 8'h42);
    wr(3'd3, 8'hB0);
    wr(3'd1, 8'h00);
    repeat (40) @(negedge pclk);
    #1 check("load_prio_tcnt", 32'(prdata), 32'h42);
    apb_read(3'd1, rd, e);
    check("load_prio_flags", 32'(rd), 32'h0);

    // Randomized traffic: prescaler ticks first, then arbitrary clk_in.
    for (int it = 0; it < 3000; it++) begin
      int r;
      logic [2:0] a;
      logic [7:0] d;
      if (it == 1500) use_rand = 1'b1;
      r = $urandom_range(0, 99);
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      if (a == 3'd3 && $urandom_range(0, 3) != 0) d[7] = 1'b0;
      if (a == 3'd1 && $urandom_range(0, 3) != 0) d = 8'hFF;
      if (r < 2) begin
        @(negedge pclk); preset_n = 1'b1;
        @(negedge pclk); preset_n = 1'b0;
      end else if (r < 40) begin
        apb_write(a, d, (r < 6) ? 2 : 1, e);
      end else if (r < 55) begin
        apb_read(a, rd, e);
      end else begin
        @(negedge pclk);
        psel = 1'($urandom); penable = 1'b0; pwrite = 1'($urandom);
        paddr = (r < 80) ? 3'd4 : a;
      end
    end

    @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
